// File: rtl/cache_types.sv
// Shared types and burst geometry for the PCS cache-line adapter.
package cache_types;

    localparam int BURST_BEATS = 4;
    localparam int BEAT_WIDTH  = 64;
    localparam int LINE_WIDTH  = BURST_BEATS * BEAT_WIDTH;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_CMD  = 3'd1,
        RD_DATA = 3'd2,
        WR_DATA = 3'd3,
        RESP    = 3'd4
    } adapter_state_t;

    function automatic logic [31:0] line_align(input logic [31:0] addr);
        return {addr[31:5], 5'b00000};
    endfunction

endpackage

// File: rtl/pcs_cacheline_adapter.sv
// Converts 256-bit cache line fills/writebacks into 4-beat 64-bit bursts.
// Optional macro PCS_ADAPTER_RADDR_CHECK_EN: drop read beats with a wrong address tag and flag addr_err.
module pcs_cacheline_adapter
    import cache_types::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic [31:0]  mem_addr,
    input  logic         mem_read,
    input  logic         mem_write,
    input  logic [255:0] mem_line_wb,
    output logic [255:0] mem_line,
    output logic         mem_resp,
    output logic [31:0]  bmem_addr,
    output logic         bmem_read,
    output logic         bmem_write,
    output logic [63:0]  bmem_wdata,
    input  logic         bmem_ready,
    input  logic [31:0]  bmem_raddr,
    input  logic [63:0]  bmem_rdata,
    input  logic         bmem_rvalid,
    output logic         addr_err
);

    adapter_state_t          state_q, state_d;
    logic [1:0]              cnt_q, cnt_d;
    logic                    is_rd_q, is_rd_d;
    logic [31:0]             addr_q, addr_d;
    logic [LINE_WIDTH-1:0]   line_q, line_d;
    logic                    beat_ok_s;
    logic                    addr_unused_s;

`ifdef PCS_ADAPTER_RADDR_CHECK_EN
    logic                    addr_err_q, addr_err_d;

    assign beat_ok_s     = (bmem_raddr == addr_q);
    assign addr_err      = addr_err_q;
    assign addr_unused_s = ^mem_addr[4:0];
`else
    assign beat_ok_s     = 1'b1;
    assign addr_err      = 1'b0;
    assign addr_unused_s = ^{mem_addr[4:0], bmem_raddr};
`endif

    // Control state: FSM, beat counter, request kind and sticky error flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= 2'd0;
            is_rd_q    <= 1'b0;
`ifdef PCS_ADAPTER_RADDR_CHECK_EN
            addr_err_q <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            is_rd_q    <= is_rd_d;
`ifdef PCS_ADAPTER_RADDR_CHECK_EN
            addr_err_q <= addr_err_d;
`endif
        end
    end

    // Datapath registers carry no reset; they are always loaded before use.
    always_ff @(posedge clk) begin
        addr_q <= addr_d;
        line_q <= line_d;
    end

    // Next-state and datapath update.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        is_rd_d    = is_rd_q;
        addr_d     = addr_q;
        line_d     = line_q;
`ifdef PCS_ADAPTER_RADDR_CHECK_EN
        addr_err_d = addr_err_q;
`endif
        case (state_q)
            IDLE: begin
                if (mem_write) begin
                    addr_d  = line_align(mem_addr);
                    line_d  = mem_line_wb;
                    is_rd_d = 1'b0;
                    cnt_d   = 2'd0;
                    state_d = WR_DATA;
                end else if (mem_read) begin
                    addr_d  = line_align(mem_addr);
                    is_rd_d = 1'b1;
                    state_d = RD_CMD;
                end else begin
                    state_d = IDLE;
                end
            end
            RD_CMD: begin
                if (bmem_ready) begin
                    cnt_d   = 2'd0;
                    state_d = RD_DATA;
                end else begin
                    state_d = RD_CMD;
                end
            end
            RD_DATA: begin
                if (bmem_rvalid && beat_ok_s) begin
                    line_d[int'(cnt_q) * BEAT_WIDTH +: BEAT_WIDTH] = bmem_rdata;
                    cnt_d = cnt_q + 2'd1;
                    if (cnt_q == 2'd3) begin
                        state_d = RESP;
                    end else begin
                        state_d = RD_DATA;
                    end
                end else begin
`ifdef PCS_ADAPTER_RADDR_CHECK_EN
                    if (bmem_rvalid) begin
                        addr_err_d = 1'b1;
                    end else begin
                        addr_err_d = addr_err_q;
                    end
`endif
                    state_d = RD_DATA;
                end
            end
            WR_DATA: begin
                if (bmem_ready) begin
                    cnt_d = cnt_q + 2'd1;
                    if (cnt_q == 2'd3) begin
                        state_d = RESP;
                    end else begin
                        state_d = WR_DATA;
                    end
                end else begin
                    state_d = WR_DATA;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Output decode straight from registered state.
    always_comb begin
        bmem_read  = 1'b0;
        bmem_write = 1'b0;
        bmem_addr  = {32{1'bx}};
        bmem_wdata = {BEAT_WIDTH{1'bx}};
        mem_resp   = 1'b0;
        mem_line   = {LINE_WIDTH{1'bx}};
        case (state_q)
            RD_CMD: begin
                bmem_read = 1'b1;
                bmem_addr = addr_q;
            end
            WR_DATA: begin
                bmem_write = 1'b1;
                bmem_addr  = addr_q;
                bmem_wdata = line_q[int'(cnt_q) * BEAT_WIDTH +: BEAT_WIDTH];
            end
            RESP: begin
                mem_resp = 1'b1;
                if (is_rd_q) begin
                    mem_line = line_q;
                end else begin
                    mem_line = {LINE_WIDTH{1'bx}};
                end
            end
            default: begin
                bmem_read = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_pcs_cacheline_adapter.sv
// Directed, table-driven bench for pcs_cacheline_adapter.
module tb_pcs_cacheline_adapter;

    logic         clk = 1'b0;
    logic         rst;
    logic [31:0]  mem_addr;
    logic         mem_read;
    logic         mem_write;
    logic [255:0] mem_line_wb;
    logic [255:0] mem_line;
    logic         mem_resp;
    logic [31:0]  bmem_addr;
    logic         bmem_read;
    logic         bmem_write;
    logic [63:0]  bmem_wdata;
    logic         bmem_ready;
    logic [31:0]  bmem_raddr;
    logic [63:0]  bmem_rdata;
    logic         bmem_rvalid;
    logic         addr_err;

    int n_pass  = 0;
    int n_total = 0;

    typedef struct {
        logic         wr;
        logic [31:0]  addr;
        logic [255:0] wb;
        logic [63:0]  beat [4];
        logic [31:0]  exp_addr;
        logic [255:0] exp_line;
    } vec_t;

    vec_t vecs [4];

    pcs_cacheline_adapter dut (
        .clk(clk), .rst(rst),
        .mem_addr(mem_addr), .mem_read(mem_read), .mem_write(mem_write),
        .mem_line_wb(mem_line_wb), .mem_line(mem_line), .mem_resp(mem_resp),
        .bmem_addr(bmem_addr), .bmem_read(bmem_read), .bmem_write(bmem_write),
        .bmem_wdata(bmem_wdata), .bmem_ready(bmem_ready), .bmem_raddr(bmem_raddr),
        .bmem_rdata(bmem_rdata), .bmem_rvalid(bmem_rvalid), .addr_err(addr_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Entered in RD_CMD; optional command stall, optional stray beat before beat 1.
    task automatic read_body(input logic [31:0] ea, input logic [63:0] bt [4],
                             input logic [255:0] el, input logic [31:0] ra,
                             input int cmd_stall, input logic stray);
        chk("rd_cmd_read", bmem_read, 1'b1);
        chk("rd_cmd_addr", bmem_addr, ea);
        for (int i = 0; i < cmd_stall; i++) begin
            bmem_ready  = 1'b0;
            bmem_rvalid = 1'b1;
            bmem_rdata  = 64'hBAD0_BAD0_BAD0_BAD0;
            tick();
            chk("rd_cmd_hold", bmem_read, 1'b1);
        end
        bmem_ready  = 1'b1;
        bmem_rvalid = 1'b0;
        tick();
        chk("rd_data_cmd_off", bmem_read, 1'b0);
        for (int k = 0; k < 4; k++) begin
            if (stray && k == 1) begin
                bmem_rvalid = 1'b1;
                bmem_raddr  = 32'hDEAD_0000;
                bmem_rdata  = 64'hFFFF_0000_FFFF_0000;
                tick();
                chk("rd_stray_no_resp", mem_resp, 1'b0);
            end
            bmem_rvalid = 1'b1;
            bmem_raddr  = ra;
            bmem_rdata  = bt[k];
            chk("rd_beat_no_resp", mem_resp, 1'b0);
            tick();
        end
        bmem_rvalid = 1'b0;
        chk("rd_resp", mem_resp, 1'b1);
        chk("rd_line", mem_line, el);
        mem_read = 1'b0;
        tick();
        chk("rd_resp_one_cycle", mem_resp, 1'b0);
    endtask

    task automatic do_read(input vec_t v, input logic [31:0] ra, input int cmd_stall, input logic stray);
        mem_read = 1'b1;
        mem_addr = v.addr;
        tick();
        read_body(v.exp_addr, v.beat, v.exp_line, ra, cmd_stall, stray);
    endtask

    // mem_write (and possibly mem_read) already raised by the caller at cycle 0.
    task automatic write_body(input vec_t v, input int stall_k);
        tick();
        for (int k = 0; k < 4; k++) begin
            if (k == stall_k) begin
                bmem_ready = 1'b0;
                for (int s = 0; s < 2; s++) begin
                    chk("wr_stall_hold", bmem_wdata, v.beat[k]);
                    tick();
                end
                bmem_ready = 1'b1;
            end
            chk("wr_strobe", bmem_write, 1'b1);
            chk("wr_no_read", bmem_read, 1'b0);
            chk("wr_addr", bmem_addr, v.exp_addr);
            chk("wr_data", bmem_wdata, v.beat[k]);
            chk("wr_no_resp", mem_resp, 1'b0);
            tick();
        end
        chk("wr_resp", mem_resp, 1'b1);
        chk("wr_strobe_off", bmem_write, 1'b0);
        mem_write = 1'b0;
        tick();
        chk("wr_resp_one_cycle", mem_resp, 1'b0);
    endtask

    task automatic do_write(input vec_t v, input int stall_k);
        mem_write   = 1'b1;
        mem_addr    = v.addr;
        mem_line_wb = v.wb;
        write_body(v, stall_k);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        vecs[0].wr       = 1'b0;
        vecs[0].addr     = 32'h1000_0024;
        vecs[0].wb       = 256'h0;
        vecs[0].beat     = '{64'h0000_0000_0000_0000, 64'h1111_1111_1111_1111,
                             64'h2222_2222_2222_2222, 64'h3333_3333_3333_3333};
        vecs[0].exp_addr = 32'h1000_0020;
        vecs[0].exp_line = {64'h3333_3333_3333_3333, 64'h2222_2222_2222_2222,
                            64'h1111_1111_1111_1111, 64'h0000_0000_0000_0000};

        vecs[1].wr       = 1'b1;
        vecs[1].addr     = 32'h2000_003F;
        vecs[1].wb       = {64'hDDDD_DDDD_DDDD_DDDD, 64'hCCCC_CCCC_CCCC_CCCC,
                            64'hBBBB_BBBB_BBBB_BBBB, 64'hAAAA_AAAA_AAAA_AAAA};
        vecs[1].beat     = '{64'hAAAA_AAAA_AAAA_AAAA, 64'hBBBB_BBBB_BBBB_BBBB,
                             64'hCCCC_CCCC_CCCC_CCCC, 64'hDDDD_DDDD_DDDD_DDDD};
        vecs[1].exp_addr = 32'h2000_0020;
        vecs[1].exp_line = 256'h0;

        vecs[2].wr       = 1'b0;
        vecs[2].addr     = 32'hFFFF_FFFF;
        vecs[2].wb       = 256'h0;
        vecs[2].beat     = '{64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210,
                             64'hDEAD_BEEF_CAFE_F00D, 64'h0000_0000_FFFF_FFFF};
        vecs[2].exp_addr = 32'hFFFF_FFE0;
        vecs[2].exp_line = {64'h0000_0000_FFFF_FFFF, 64'hDEAD_BEEF_CAFE_F00D,
                            64'hFEDC_BA98_7654_3210, 64'h0123_4567_89AB_CDEF};

        vecs[3].wr       = 1'b1;
        vecs[3].addr     = 32'h0000_0000;
        vecs[3].wb       = {64'h0000_0000_0000_0001, 64'h8000_0000_0000_0000,
                            64'hFFFF_FFFF_FFFF_FFFF, 64'h5555_5555_5555_5555};
        vecs[3].beat     = '{64'h5555_5555_5555_5555, 64'hFFFF_FFFF_FFFF_FFFF,
                             64'h8000_0000_0000_0000, 64'h0000_0000_0000_0001};
        vecs[3].exp_addr = 32'h0000_0000;
        vecs[3].exp_line = 256'h0;

        rst = 1'b1; mem_addr = 32'h0; mem_read = 1'b0; mem_write = 1'b0;
        mem_line_wb = 256'h0; bmem_ready = 1'b1; bmem_raddr = 32'h0;
        bmem_rdata = 64'h0; bmem_rvalid = 1'b0;
        tick(); tick();
        chk("rst_resp", mem_resp, 1'b0);
        chk("rst_read", bmem_read, 1'b0);
        chk("rst_write", bmem_write, 1'b0);
        chk("rst_addr_err", addr_err, 1'b0);
        rst = 1'b0;
        tick();

        for (int i = 0; i < 4; i++) begin
            if (vecs[i].wr) do_write(vecs[i], -1);
            else do_read(vecs[i], vecs[i].exp_addr, 0, 1'b0);
        end

        // Write with bmem_ready low for two cycles on beat 1.
        do_write(vecs[1], 1);

        // Read with a command stall and a stray rvalid while in RD_CMD.
        do_read(vecs[2], vecs[2].exp_addr, 2, 1'b0);

        // Simultaneous request: write first, then read while mem_read stays high.
        mem_read = 1'b1; mem_write = 1'b1; mem_addr = 32'h1000_0024; mem_line_wb = vecs[1].wb;
        vecs[1].exp_addr = 32'h1000_0020;
        write_body(vecs[1], -1);
        chk("both_idle_gap", bmem_read, 1'b0);
        tick();
        read_body(32'h1000_0020, vecs[0].beat, vecs[0].exp_line, 32'h1000_0020, 0, 1'b0);

        // Simultaneous request with mem_read dropped: no read follows.
        mem_read = 1'b1; mem_write = 1'b1; mem_addr = 32'h2000_0000; mem_line_wb = vecs[3].wb;
        vecs[3].exp_addr = 32'h2000_0000;
        write_body(vecs[3], -1);
        mem_read = 1'b0;
        tick();
        chk("both_no_read", bmem_read, 1'b0);
        chk("both_no_write", bmem_write, 1'b0);

        // Reset after three read beats abandons the burst.
        mem_read = 1'b1; mem_addr = 32'h3000_0040;
        tick(); tick();
        for (int k = 0; k < 3; k++) begin
            bmem_rvalid = 1'b1; bmem_raddr = 32'h3000_0040; bmem_rdata = 64'hEEEE_EEEE_EEEE_EEEE;
            tick();
        end
        bmem_rvalid = 1'b0; mem_read = 1'b0; rst = 1'b1;
        tick();
        chk("midrst_resp", mem_resp, 1'b0);
        chk("midrst_read", bmem_read, 1'b0);
        chk("midrst_write", bmem_write, 1'b0);
        rst = 1'b0;
        tick();
        chk("midrst_resp_after", mem_resp, 1'b0);
        do_read(vecs[0], vecs[0].exp_addr, 0, 1'b0);

`ifdef PCS_ADAPTER_RADDR_CHECK_EN
        do_read(vecs[2], vecs[2].exp_addr, 0, 1'b1);
        chk("raddr_err_set", addr_err, 1'b1);
        tick();
        chk("raddr_err_sticky", addr_err, 1'b1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("raddr_err_cleared", addr_err, 1'b0);
`else
        do_read(vecs[2], 32'hDEAD_0000, 0, 1'b0);
        chk("raddr_ignored_err", addr_err, 1'b0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
